pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage Y86-64 pipeline. It holds the architectural condition-code register that feeds the execute stage's branch/cmov condition logic. It generates stall/bubble controls for the F/D/E/M/W pipeline registers from hazard conditions, and runs a RUN/DRAIN/HALTED status FSM with performance counters. It sits beside the datapath, taking icode/register-id/stat taps from each stage.

Parameters:
CNT_W, 32, width of cycle/retire/stall performance counters (saturating)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
D_icode  input  4  icode in decode register
d_srcA  input  4  decode source register A (4'hF = none)
d_srcB  input  4  decode source register B (4'hF = none)
E_icode  input  4  icode in execute register
E_dstM  input  4  execute-stage memory destination register
e_cnd  input  1  condition result from execute stage
alu_zf  input  1  ZF computed by execute ALU this cycle
alu_sf  input  1  SF computed by execute ALU this cycle
alu_of  input  1  OF computed by execute ALU this cycle
M_icode  input  4  icode in memory register
m_stat  input  4  status leaving memory stage
W_stat  input  4  status in writeback register
cc_zf  output  1  registered ZF to execute
cc_sf  output  1  registered SF to execute
cc_of  output  1  registered OF to execute
F_stall  output  1  hold fetch PC register
D_stall  output  1  hold decode register
D_bubble  output  1  load nop into decode register
E_bubble  output  1  load nop into execute register
M_bubble  output  1  load nop into memory register
W_stall  output  1  hold writeback register
halted  output  1  FSM in HALTED
exc_stat  output  4  status that caused halt (latched)
cycle_cnt  output  CNT_W  cycles spent in RUN or DRAIN
retire_cnt  output  CNT_W  instructions retired with AOK
stall_cnt  output  CNT_W  cycles with F_stall asserted in RUN

Behaviour:
- Constants: icodes HALT=0 NOP=1 CMOV=2 IRMOV=3 RMMOV=4 MRMOV=5 OPQ=6 JXX=7 CALL=8 RET=9 PUSH=A POP=B; stat BUB=0 AOK=1 HLT=2 ADR=3 INS=4; RNONE=4'hF. A status is "exceptional" when it is HLT, ADR or INS.
- Reset (async, rst_n=0): cc_zf=1, cc_sf=0, cc_of=0; FSM=RUN; exc_stat=AOK; all counters 0. Hazard outputs are combinational and reset-independent, except that they take their HALTED values while halted.
- Hazard terms, all combinational:
  - load_use = (E_icode is MRMOV or POP) and E_dstM != RNONE and E_dstM equals d_srcA or d_srcB.
  - ret_haz = RET in any of D_icode, E_icode, M_icode.
  - mispred = E_icode==JXX and !e_cnd.
  - m_exc = m_stat exceptional; w_exc = W_stat exceptional.
- Outputs in RUN/DRAIN:
  - F_stall = load_use | ret_haz.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_haz & !load_use).
  - E_bubble = mispred | load_use.
  - M_bubble = m_exc | w_exc.
  - W_stall = w_exc.
- Priority: load_use beats ret_haz for decode, so D_stall=1 and D_bubble=0 together. D_stall and D_bubble are never both 1.
- CC update:
  - set_cc = E_icode==OPQ & !m_exc & !w_exc & FSM!=HALTED.
  - On the clk edge with set_cc, cc_* <= alu_*. Otherwise cc_* hold.
  - Each new CC value is visible to the execute stage from the next cycle (1-cycle latency).
- FSM:
  - RUN -> DRAIN when m_exc & !w_exc.
  - RUN or DRAIN -> HALTED when w_exc; exc_stat <= W_stat on that edge.
  - DRAIN -> RUN does not occur (an exception in M always reaches W).
  - HALTED is sticky until reset.
  - In HALTED: F_stall=D_stall=W_stall=1, D_bubble=E_bubble=M_bubble=0, no CC update.
- Counters:
  - cycle_cnt increments every cycle while state != HALTED.
  - retire_cnt increments when W_stat==AOK and state != HALTED.
  - stall_cnt increments when F_stall and state==RUN.
  - All counters saturate at all-ones; no wrap.
- Reset asserted mid-operation restores all reset values immediately, regardless of FSM state or pending hazards.

Decomposition:
- Shared package y86_pkg: icode constants, stat codes, RNONE. The datapath stages use the same package.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count). It is instantiated three times.
- Hazard decode, CC register and FSM stay in pipe_ctrl.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> cc_zf=1, cc_sf=0, cc_of=0, halted=0, exc_stat=1, counters=0. After 10 AOK cycles, cycle_cnt=10 and retire_cnt=10.
- Load/use: E_icode=5, E_dstM=3, d_srcA=3, plus D_icode=9 -> F_stall=1, D_stall=1, D_bubble=0, E_bubble=1.
- Mispredict: E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. With e_cnd=1 instead -> all controls 0.
- CC: E_icode=6 with alu_zf=0, alu_sf=1, alu_of=1 -> after the edge, cc_*=0/1/1. Same inputs with m_stat=3 -> cc unchanged and M_bubble=1.
- Halt sequence: m_stat=2 -> DRAIN, M_bubble=1. Next cycle W_stat=2 -> halted=1, exc_stat=2, W_stall=1, counters frozen. Then pulse rst_n low -> RUN with all reset values.
- Saturation: CNT_W=4 with 20 RUN cycles -> cycle_cnt=15 and holds there.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the Y86-64 pipeline datapath and control.
//   - instruction codes (icode field)
//   - stage status codes (stat field)
//   - RNONE register id
//   - control FSM state encoding
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] S_BUB = 4'h0;
    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_e;

    // A status stops the machine when it is HLT, ADR or INS.
    function automatic logic is_exc(input logic [3:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears count
//   inc    - increment enable for this cycle
//   count  - current count value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the 5-stage Y86-64 pipeline.
//   Inputs : icode/register/status taps from D, E, M, W stages plus the
//            execute ALU flags and branch condition.
//   Outputs: condition-code register (cc_*), pipeline-register stall and
//            bubble controls, halted flag with latched exception status,
//            and saturating cycle / retire / stall performance counters.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_RUN    | normal operation
// ST_DRAIN  | exception seen in M, waiting for it to reach W
// ST_HALTED | exception reached W; pipeline frozen until reset
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [3:0]       exc_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_state_e state_q, state_d;
    logic [2:0]  cc_q, cc_d;          // {zf, sf, of}
    logic [3:0]  exc_stat_q, exc_stat_d;

    logic load_use, ret_haz, mispred, m_exc, w_exc, set_cc;
    logic in_halt;

    assign load_use = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                      (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_haz  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred  = (E_icode == I_JXX) && !e_cnd;
    assign m_exc    = is_exc(m_stat);
    assign w_exc    = is_exc(W_stat);
    assign in_halt  = (state_q == ST_HALTED);

    // An excepting instruction in M or W must not let a younger OPQ
    // change the architectural flags.
    assign set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc && !in_halt;

    always_comb begin
        F_stall  = load_use | ret_haz;
        D_stall  = load_use;
        // load_use wins over ret_haz so decode is held rather than flushed.
        D_bubble = mispred | (ret_haz & ~load_use);
        E_bubble = mispred | load_use;
        M_bubble = m_exc | w_exc;
        W_stall  = w_exc;
        if (in_halt) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b0;
            W_stall  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        exc_stat_d = exc_stat_q;
        cc_d       = cc_q;
        if (set_cc) begin
            cc_d = {alu_zf, alu_sf, alu_of};
        end
        case (state_q)
            ST_RUN, ST_DRAIN: begin
                if (w_exc) begin
                    state_d    = ST_HALTED;
                    exc_stat_d = W_stat;
                end else if (m_exc) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cc_q       <= 3'b100;
            exc_stat_q <= S_AOK;
        end else begin
            state_q    <= state_d;
            cc_q       <= cc_d;
            exc_stat_q <= exc_stat_d;
        end
    end

    assign cc_zf    = cc_q[2];
    assign cc_sf    = cc_q[1];
    assign cc_of    = cc_q[0];
    assign halted   = in_halt;
    assign exc_stat = exc_stat_q;

    logic cycle_inc, retire_inc, stall_inc;
    assign cycle_inc  = !in_halt;
    assign retire_inc = (W_stat == S_AOK) && !in_halt;
    assign stall_inc  = F_stall && (state_q == ST_RUN);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cycle_inc),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire_inc),
        .count (retire_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule
